// File: rtl/trap_sequencer.sv
// trap_sequencer: edge-latched interrupt sequencer (save/vector/handler/return).
// Define TRAP_VECTORED_EN for per-source vectored handler addresses.
module trap_sequencer #(
    parameter int unsigned     NUM_SOURCES = 4,
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0010
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic [NUM_SOURCES-1:0] irqIn,
    input  logic [NUM_SOURCES-1:0] irqMask,
    input  logic [XLEN-1:0]        currentPc,
    input  logic                   mretIn,
    input  logic                   mieWrite,
    input  logic                   mieWriteData,
    output logic                   isTrap,
    output logic [XLEN-1:0]        trapTarget,
    output logic                   isReturn,
    output logic                   csrWriteEnable,
    output logic                   stallFetch,
    output logic [NUM_SOURCES-1:0] irqAck,
    output logic [XLEN-1:0]        mepc,
    output logic [XLEN-1:0]        mcause,
    output logic                   mie
);

    localparam int unsigned IDX_W =
        (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_VECTOR,
        S_HANDLER,
        S_RETURN
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_SOURCES-1:0] irq_prev_q;
    logic [NUM_SOURCES-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]       claim_idx_q, claim_idx_d;
    logic [XLEN-1:0]        mepc_q, mepc_d;
    logic [XLEN-1:0]        mcause_q, mcause_d;
    logic                   mie_q, mie_d;
    logic                   is_trap_q, is_trap_d;
    logic                   is_return_q, is_return_d;
    logic                   csr_we_q, csr_we_d;
    logic                   stall_q, stall_d;
    logic [NUM_SOURCES-1:0] irq_ack_q, irq_ack_d;

    logic [NUM_SOURCES-1:0] eligible;
    logic                   any_eligible;
    logic [IDX_W-1:0]       low_idx;
    logic [XLEN-1:0]        cause_val;
    logic                   mie_cleared;

    assign eligible     = pending_q & irqMask;
    assign any_eligible = |eligible;
    assign mie_cleared  = mieWrite & ~mieWriteData;

    // Lowest set eligible bit wins (bit 0 is highest priority).
    always_comb begin
        low_idx = '0;
        for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Cause word: interrupt flag in the MSB, claimed source in the low bits.
    always_comb begin
        cause_val = '0;
        cause_val[XLEN-1] = 1'b1;
        cause_val[IDX_W-1:0] = claim_idx_q;
    end

    // New rising edges set pending; the ack pulse clears, set taking priority.
    always_comb begin
        pending_d = (pending_q & ~irq_ack_q) | (irqIn & ~irq_prev_q);
    end

    // Sequencer next-state, CSR updates and next registered output values.
    always_comb begin
        state_d     = state_q;
        claim_idx_d = claim_idx_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mie_d       = mie_q;
        unique case (state_q)
            S_IDLE: begin
                if (mieWrite) begin
                    mie_d = mieWriteData;
                end
                if (mie_q && any_eligible && !mie_cleared) begin
                    state_d     = S_SAVE;
                    claim_idx_d = low_idx;
                end
            end
            S_SAVE: begin
                mepc_d   = currentPc;
                mcause_d = cause_val;
                mie_d    = 1'b0;
                state_d  = S_VECTOR;
            end
            S_VECTOR: begin
                state_d = S_HANDLER;
            end
            S_HANDLER: begin
                if (mretIn) begin
                    state_d = S_RETURN;
                end
            end
            S_RETURN: begin
                mie_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        is_trap_d   = (state_d == S_VECTOR);
        is_return_d = (state_d == S_RETURN);
        csr_we_d    = (state_d == S_SAVE);
        stall_d     = (state_d == S_SAVE);
        irq_ack_d   = (state_d == S_SAVE) ?
                      (NUM_SOURCES'(1) << claim_idx_d) : '0;
    end

    // FSM state, claim latch and registered control outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            claim_idx_q <= '0;
            is_trap_q   <= 1'b0;
            is_return_q <= 1'b0;
            csr_we_q    <= 1'b0;
            stall_q     <= 1'b0;
            irq_ack_q   <= '0;
        end else begin
            state_q     <= state_d;
            claim_idx_q <= claim_idx_d;
            is_trap_q   <= is_trap_d;
            is_return_q <= is_return_d;
            csr_we_q    <= csr_we_d;
            stall_q     <= stall_d;
            irq_ack_q   <= irq_ack_d;
        end
    end

    // Request edge detector and pending latches.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
        end else begin
            irq_prev_q <= irqIn;
            pending_q  <= pending_d;
        end
    end

    // Machine CSRs: return PC, cause and global enable.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mepc_q   <= '0;
            mcause_q <= '0;
            mie_q    <= 1'b0;
        end else begin
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mie_q    <= mie_d;
        end
    end

`ifdef TRAP_VECTORED_EN
    assign trapTarget = TRAP_VECTOR + (XLEN'(claim_idx_q) << 2);
`else
    assign trapTarget = TRAP_VECTOR;
`endif

    assign isTrap         = is_trap_q;
    assign isReturn       = is_return_q;
    assign csrWriteEnable = csr_we_q;
    assign stallFetch     = stall_q;
    assign irqAck         = irq_ack_q;
    assign mepc           = mepc_q;
    assign mcause         = mcause_q;
    assign mie            = mie_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed stimulus with a queued scoreboard
// checked by a monitor on every ack/trap/return pulse.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        resetN;
    logic [3:0]  irqIn;
    logic [3:0]  irqMask;
    logic [31:0] currentPc;
    logic        mretIn;
    logic        mieWrite;
    logic        mieWriteData;
    logic        isTrap;
    logic [31:0] trapTarget;
    logic        isReturn;
    logic        csrWriteEnable;
    logic        stallFetch;
    logic [3:0]  irqAck;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        mie;

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
    } ev_t;

    ev_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;

    trap_sequencer #(
        .NUM_SOURCES(4),
        .XLEN(32),
        .TRAP_VECTOR(32'h0000_0010)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .irqIn(irqIn),
        .irqMask(irqMask),
        .currentPc(currentPc),
        .mretIn(mretIn),
        .mieWrite(mieWrite),
        .mieWriteData(mieWriteData),
        .isTrap(isTrap),
        .trapTarget(trapTarget),
        .isReturn(isReturn),
        .csrWriteEnable(csrWriteEnable),
        .stallFetch(stallFetch),
        .irqAck(irqAck),
        .mepc(mepc),
        .mcause(mcause),
        .mie(mie)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] tgt(input int idx);
`ifdef TRAP_VECTORED_EN
        return 32'h10 + 32'(idx << 2);
`else
        return 32'h10 + 32'(idx * 0);
`endif
    endfunction

    task automatic push(input string name, input int c,
                        input logic [31:0] v0, input logic [31:0] v1,
                        input logic [31:0] v2);
        ev_t e;
        e.name = name;
        e.cyc  = c;
        e.v0   = v0;
        e.v1   = v1;
        e.v2   = v2;
        sb.push_back(e);
    endtask

    task automatic observe(input string name, input logic [31:0] v0,
                           input logic [31:0] v1, input logic [31:0] v2);
        ev_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_%s: cyc=%0d got %h/%h/%h, want no event",
                     name, cyc, v0, v1, v2);
        end else begin
            e = sb.pop_front();
            if (e.name != name || e.cyc != cyc || e.v0 !== v0 ||
                e.v1 !== v1 || e.v2 !== v2) begin
                fails++;
                $display("FAIL %s: got %s@%0d %h/%h/%h, want %s@%0d %h/%h/%h",
                         e.name, name, cyc, v0, v1, v2,
                         e.name, e.cyc, e.v0, e.v1, e.v2);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every pulse the DUT presents must match the queue head.
    always @(negedge clk) begin
        if (irqAck != 4'd0 || csrWriteEnable || stallFetch)
            observe("ack", {22'd0, csrWriteEnable, stallFetch, 4'd0, irqAck},
                    32'd0, 32'd0);
        if (isTrap)
            observe("trap", trapTarget, mepc, mcause);
        if (isReturn)
            observe("ret", mepc, {31'd0, mie}, 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int q;
        resetN       = 1'b0;
        irqIn        = 4'd0;
        irqMask      = 4'hF;
        currentPc    = 32'd0;
        mretIn       = 1'b0;
        mieWrite     = 1'b0;
        mieWriteData = 1'b0;

        // Reset state
        tick(3);
        chk("rst_mie", {31'd0, mie}, 32'd0);
        chk("rst_mepc", mepc, 32'd0);
        chk("rst_mcause", mcause, 32'd0);
        resetN = 1'b1;
        tick(20);
        chk("post_rst_mie", {31'd0, mie}, 32'd0);
        chk("post_rst_mepc", mepc, 32'd0);

        // Single trap and return
        mieWrite = 1'b1;
        mieWriteData = 1'b1;
        tick(1);
        mieWrite = 1'b0;
        currentPc = 32'h40;
        irqIn = 4'b0100;
        e = cyc;
        push("ack", e + 2, 32'h304, 0, 0);
        push("trap", e + 3, tgt(2), 32'h40, 32'h8000_0002);
        tick(1);
        irqIn = 4'd0;
        tick(5);
        chk("s1_mepc", mepc, 32'h40);
        chk("s1_mcause", mcause, 32'h8000_0002);
        chk("s1_mie_off", {31'd0, mie}, 32'd0);
        mretIn = 1'b1;
        q = cyc;
        push("ret", q + 1, 32'h40, 32'd0, 32'd0);
        tick(1);
        mretIn = 1'b0;
        tick(2);
        chk("s1_mie_back", {31'd0, mie}, 32'd1);

        // Priority: sources 1 and 3 together
        currentPc = 32'h100;
        irqIn = 4'b1010;
        e = cyc;
        push("ack", e + 2, 32'h302, 0, 0);
        push("trap", e + 3, tgt(1), 32'h100, 32'h8000_0001);
        tick(1);
        irqIn = 4'd0;
        tick(5);
        currentPc = 32'h200;
        mretIn = 1'b1;
        q = cyc;
        push("ret", q + 1, 32'h100, 32'd0, 32'd0);
        push("ack", q + 3, 32'h308, 0, 0);
        push("trap", q + 4, tgt(3), 32'h200, 32'h8000_0003);
        tick(1);
        mretIn = 1'b0;
        tick(6);
        mretIn = 1'b1;
        q = cyc;
        push("ret", q + 1, 32'h200, 32'd0, 32'd0);
        tick(1);
        mretIn = 1'b0;
        tick(3);

        // Masking: source 0 held off until its mask bit is set
        irqMask = 4'b1110;
        irqIn = 4'b0001;
        tick(1);
        irqIn = 4'd0;
        tick(8);
        currentPc = 32'h300;
        irqMask = 4'hF;
        e = cyc;
        push("ack", e + 1, 32'h301, 0, 0);
        push("trap", e + 2, tgt(0), 32'h300, 32'h8000_0000);
        tick(5);

        // Nesting blocked while in the handler
        irqIn = 4'b0001;
        tick(1);
        irqIn = 4'd0;
        tick(4);
        currentPc = 32'h340;
        mretIn = 1'b1;
        q = cyc;
        push("ret", q + 1, 32'h300, 32'd0, 32'd0);
        push("ack", q + 3, 32'h301, 0, 0);
        push("trap", q + 4, tgt(0), 32'h340, 32'h8000_0000);
        tick(1);
        mretIn = 1'b0;
        tick(5);
        mretIn = 1'b1;
        q = cyc;
        push("ret", q + 1, 32'h340, 32'd0, 32'd0);
        tick(1);
        mretIn = 1'b0;
        tick(3);

        // MRET in IDLE does nothing
        mretIn = 1'b1;
        tick(1);
        mretIn = 1'b0;
        tick(4);
        chk("idle_mret_mie", {31'd0, mie}, 32'd1);
        chk("idle_mret_mepc", mepc, 32'h340);

        // MIE clear coinciding with an eligible request wins
        irqMask = 4'b1011;
        irqIn = 4'b0100;
        tick(1);
        irqIn = 4'd0;
        tick(2);
        irqMask = 4'hF;
        mieWrite = 1'b1;
        mieWriteData = 1'b0;
        tick(1);
        mieWrite = 1'b0;
        tick(5);
        chk("mie_clr_wins", {31'd0, mie}, 32'd0);
        currentPc = 32'h500;
        mieWrite = 1'b1;
        mieWriteData = 1'b1;
        e = cyc;
        push("ack", e + 2, 32'h304, 0, 0);
        push("trap", e + 3, tgt(2), 32'h500, 32'h8000_0002);
        tick(1);
        mieWrite = 1'b0;
        tick(5);
        mieWrite = 1'b1;
        mieWriteData = 1'b1;
        tick(1);
        mieWrite = 1'b0;
        chk("handler_mie_write", {31'd0, mie}, 32'd0);
        mretIn = 1'b1;
        q = cyc;
        push("ret", q + 1, 32'h500, 32'd0, 32'd0);
        tick(1);
        mretIn = 1'b0;
        tick(3);

        // Reset during VECTOR abandons the trap and clears pending
        currentPc = 32'h600;
        irqIn = 4'b0010;
        e = cyc;
        push("ack", e + 2, 32'h302, 0, 0);
        tick(1);
        irqIn = 4'b1000;
        tick(1);
        irqIn = 4'd0;
        tick(1);
        chk("vec_trap_high", {31'd0, isTrap}, 32'd1);
        chk("vec_target", trapTarget, tgt(1));
        resetN = 1'b0;
        #1;
        chk("rst_trap_drop", {31'd0, isTrap}, 32'd0);
        chk("rst_mid_mepc", mepc, 32'd0);
        chk("rst_mid_mcause", mcause, 32'd0);
        chk("rst_mid_mie", {31'd0, mie}, 32'd0);
        tick(2);
        resetN = 1'b1;
        mieWrite = 1'b1;
        mieWriteData = 1'b1;
        tick(1);
        mieWrite = 1'b0;
        tick(10);
        chk("rst_mid_mie_set", {31'd0, mie}, 32'd1);

        tick(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

- Parametrised, multi-cycle interrupt and trap sequencer for the single-cycle RISC-V core.
- Accepts `NUM_SOURCES` interrupt request lines and latches each rising edge as pending.
- Selects the highest-priority enabled request and runs a fixed save → vector → handler → return sequence, driving MEPC/MCAUSE and PC-redirect controls.
- Sits beside the main instruction decoder. Its `isTrap`/`isReturn`/`stallFetch` outputs take precedence over decoder outputs in the PC and write-enable muxing.

## Interface
Parameters:
- `NUM_SOURCES`, default 4: number of interrupt request lines, 1..16.
- `XLEN`, default 32: PC and CSR width.
- `TRAP_VECTOR`, default 32'h0000_0010: trap base address.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `resetN` input 1: asynchronous, active-low reset.
- `irqIn` input NUM_SOURCES: level request lines; bit 0 is highest priority.
- `irqMask` input NUM_SOURCES: per-source enable; 1 = enabled.
- `currentPc` input XLEN: PC of the instruction to resume after the trap.
- `mretIn` input 1: decoder asserts for one cycle on MRET.
- `mieWrite` input 1: software write strobe for the global interrupt enable.
- `mieWriteData` input 1: value written to MIE.
- `isTrap` output 1: one-cycle PC redirect to `trapTarget`.
- `trapTarget` output XLEN: handler address; valid while `isTrap`=1.
- `isReturn` output 1: one-cycle PC redirect to `mepc`.
- `csrWriteEnable` output 1: high during the MEPC/MCAUSE capture cycle.
- `stallFetch` output 1: freezes PC and blocks register/memory writes.
- `irqAck` output NUM_SOURCES: one-hot, one-cycle claim pulse.
- `mepc` output XLEN: saved return PC.
- `mcause` output XLEN: bit XLEN-1 = 1 (interrupt); low bits = claimed index.
- `mie` output 1: global interrupt enable.

## Operation
- **Edge detect.** Register `irqPrev` ← `irqIn` each cycle. `pending[i]` is set when `irqIn[i] & ~irqPrev[i]`. It is cleared when `irqAck[i]`. If set and clear coincide, set wins.
- **Eligibility.** `eligible = pending & irqMask`. The claimed index is the lowest set bit of `eligible`.
- **FSM states:** IDLE, SAVE, VECTOR, HANDLER, RETURN.
- **IDLE → SAVE:** when `mie`=1 and `eligible`≠0. The claimed index is latched into `claimIdx` on this edge. Later changes to mask or pending do not alter it.
- **SAVE:**
  - Drives `stallFetch`=1, `csrWriteEnable`=1 and `irqAck[claimIdx]`=1.
  - Next edge: `mepc` ← `currentPc`, `mcause` ← {1, zeros, `claimIdx`}, `mie` ← 0.
  - Next state is always VECTOR.
- **VECTOR:** `isTrap`=1, `stallFetch`=0. Next state is always HANDLER.
- **HANDLER:**
  - Interrupts are held off because `mie`=0; pending bits keep accumulating.
  - `mretIn` → RETURN. The `mieWrite` path is ignored in this state.
- **RETURN:** `isReturn`=1. On the next edge `mie` ← 1 and the FSM returns to IDLE.
- **MRET elsewhere.** `mretIn` in IDLE, SAVE or VECTOR is ignored; no outputs change.
- **MIE writes.** `mieWrite` is honoured only in IDLE. If `mieWrite` with data 0 coincides with an eligible request, the write wins and no trap is taken.
- **Arithmetic.** `trapTarget` is computed modulo 2^XLEN; overflow wraps with no flag.
- **Reset:**
  - State → IDLE; `pending`, `irqPrev`, `claimIdx`, `mepc`, `mcause` → 0; `mie` → 0.
  - All pulse outputs → 0.
  - A reset mid-sequence abandons the trap, with no ack and no partial CSR update after reset.

## Timing
- Rising edge on `irqIn` sampled at edge E → `pending` at E+1.
- With `mie`=1, the FSM enters SAVE at E+2, VECTOR at E+3 and HANDLER at E+4.
- `isTrap` is asserted during the E+3..E+4 cycle.
- Minimum interrupt-to-redirect latency: 3 cycles.
- `mretIn` at edge R (in HANDLER) → `isReturn` high during R..R+1; `mie`=1 from R+1.
- A request already pending at R+1 enters SAVE at R+2, giving back-to-back service.
- All outputs are registered-state decodes, with no combinational path from `irqIn`.
- Exception: `trapTarget` is combinational from `claimIdx`.

## Configuration
- `TRAP_VECTORED_EN` defined: `trapTarget` = `TRAP_VECTOR` + (`claimIdx` << 2).
- `TRAP_VECTORED_EN` undefined: `trapTarget` = `TRAP_VECTOR` for every source (direct mode); the handler reads `mcause` to dispatch.

## Test plan
- **Reset.** Hold `resetN`=0, then release with all `irqIn`=0 → `mie`=0, `mepc`=0, `mcause`=0, no pulses for 20 cycles.
- **Single trap and return.**
  - Stimulus: set `mie` via `mieWrite`, `currentPc`=0x0000_0040, rising edge on `irqIn[2]`.
  - Expected: `irqAck`=4'b0100 in SAVE; `mepc`=0x40, `mcause`=0x8000_0002.
  - Expected: `isTrap` 3 cycles after the edge, `trapTarget`=0x18 (vectored) or 0x10 (direct).
  - Follow-up: `mretIn` → `isReturn`=1, `mie`=1.
- **Priority.** Simultaneous edges on `irqIn[3]` and `irqIn[1]` with mask 4'b1111 → source 1 claimed first; after MRET, source 3 enters SAVE 2 cycles after `mretIn`.
- **Masking.** Edge on `irqIn[0]` with `irqMask[0]`=0 → no trap, pending stays 1. Setting mask bit 0 → trap taken 1 cycle later.
- **Nesting blocked.** Edge on `irqIn[0]` while in HANDLER → no SAVE until after `isReturn`. An `mretIn` pulse in IDLE → no `isReturn`.
- **Reset mid-sequence.** Assert `resetN`=0 during VECTOR → `isTrap` drops immediately; after release, the FSM is in IDLE with `pending`=0.
